// File: rtl/gaussian_filter_accel_hls_dl_pkg.sv
// Shared definitions for the dataflow deadlock report controller:
// state encoding, default walk timeout and index helpers.
package gaussian_filter_accel_hls_dl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ORIGIN = 3'd1,
    ST_WALK   = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_REPORT = 3'd4
  } dl_state_e;

  localparam int DEF_TIMEOUT = 64;

  // Process-ID width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Candidate index i steps after the pointer, wrapping modulo n.
  function automatic int wrap_idx(input int ptr, input int i, input int n);
    return (ptr + 1 + i) % n;
  endfunction

endpackage

// File: rtl/gaussian_filter_accel_hls_dl_rr_arb.sv
// Combinational round-robin arbiter: the first requester after ptr wins.
// The pointer register is owned by the parent.
module gaussian_filter_accel_hls_dl_rr_arb
  import gaussian_filter_accel_hls_dl_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int ID_W     = 2
) (
  input  logic [PROC_NUM-1:0] req,
  input  logic [ID_W-1:0]     ptr,
  output logic [PROC_NUM-1:0] grant,
  output logic [ID_W-1:0]     grant_id,
  output logic                any
);

  // Priority scan starting just above the last winner.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 0; i < PROC_NUM; i++) begin
      if (!any && req[ID_W'(wrap_idx(int'(ptr), i, PROC_NUM))]) begin
        grant[ID_W'(wrap_idx(int'(ptr), i, PROC_NUM))] = 1'b1;
        grant_id = ID_W'(wrap_idx(int'(ptr), i, PROC_NUM));
        any      = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/gaussian_filter_accel_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer: picks a token origin, tracks the token walk
// around the dependence cycle and holds the resulting report until acked.
module gaussian_filter_accel_hls_deadlock_report_ctrl
  import gaussian_filter_accel_hls_dl_pkg::*;
#(
  parameter int PROC_NUM = 4,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int ID_W     = id_width(PROC_NUM)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [PROC_NUM-1:0]          dl_detect_vec,
  input  logic [PROC_NUM-1:0]          token_vec,
  input  logic                         report_ack,
  output logic                         dl_detect_in,
  output logic [PROC_NUM-1:0]          origin_vec,
  output logic                         token_clear,
  output logic                         report_vld,
  output logic [ID_W-1:0]              report_id,
  output logic [PROC_NUM-1:0]          report_mask,
  output logic [$clog2(TIMEOUT+1)-1:0] report_len,
  output logic                         abort_pulse
);

  localparam int LEN_W = $clog2(TIMEOUT + 1);

  dl_state_e             state_r, next_state_s;
  logic [ID_W-1:0]       cur_id_r, last_winner_r, grant_id_s;
  logic [PROC_NUM-1:0]   cur_oh_r, grant_s, mask_r;
  logic [LEN_W-1:0]      len_r, len_inc_s;
  logic                  any_s, abort_s;
  logic                  dl_detect_in_r, report_vld_r, abort_pulse_r;
  logic [ID_W-1:0]       report_id_r;
  logic [PROC_NUM-1:0]   report_mask_r;
  logic [LEN_W-1:0]      report_len_r;

  gaussian_filter_accel_hls_dl_rr_arb #(
    .PROC_NUM (PROC_NUM),
    .ID_W     (ID_W)
  ) u_arb (
    .req      (dl_detect_vec),
    .ptr      (last_winner_r),
    .grant    (grant_s),
    .grant_id (grant_id_s),
    .any      (any_s)
  );

  // Walk length saturates at the timeout value.
  always_comb begin
    if (len_r == LEN_W'(TIMEOUT)) begin
      len_inc_s = len_r;
    end else begin
      len_inc_s = len_r + LEN_W'(1);
    end
  end

  // Next-state decode; token return takes priority over timeout.
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) next_state_s = ST_ORIGIN;
        else       next_state_s = ST_IDLE;
      end
      ST_ORIGIN: next_state_s = ST_WALK;
      ST_WALK: begin
        if (token_vec[cur_id_r]) begin
          next_state_s = ST_CLEAR;
        end else if (len_inc_s == LEN_W'(TIMEOUT)) begin
          next_state_s = ST_IDLE;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_WALK;
        end
      end
      ST_CLEAR: next_state_s = ST_REPORT;
      ST_REPORT: begin
        if (report_ack) next_state_s = ST_IDLE;
        else            next_state_s = ST_REPORT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, walk tracking, report holding and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      cur_id_r       <= '0;
      cur_oh_r       <= '0;
      last_winner_r  <= ID_W'(PROC_NUM - 1);
      mask_r         <= '0;
      len_r          <= '0;
      dl_detect_in_r <= 1'b0;
      report_vld_r   <= 1'b0;
      abort_pulse_r  <= 1'b0;
      report_id_r    <= '0;
      report_mask_r  <= '0;
      report_len_r   <= '0;
    end else begin
      state_r        <= next_state_s;
      dl_detect_in_r <= (next_state_s != ST_IDLE);
      report_vld_r   <= (next_state_s == ST_REPORT);
      abort_pulse_r  <= abort_s;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            cur_id_r      <= grant_id_s;
            cur_oh_r      <= grant_s;
            last_winner_r <= grant_id_s;
          end
        end
        ST_ORIGIN: begin
          mask_r <= cur_oh_r;
          len_r  <= '0;
        end
        ST_WALK: begin
          mask_r <= mask_r | token_vec;
          len_r  <= len_inc_s;
        end
        ST_CLEAR: begin
          report_id_r   <= cur_id_r;
          report_mask_r <= mask_r;
          report_len_r  <= len_r;
        end
        ST_REPORT: begin
          // Report fields read as zero again once the block is back in IDLE.
          if (report_ack) begin
            report_id_r   <= '0;
            report_mask_r <= '0;
            report_len_r  <= '0;
          end
        end
        default: begin
          mask_r <= mask_r;
        end
      endcase
    end
  end

  assign origin_vec   = (state_r == ST_ORIGIN) ? cur_oh_r : '0;
  assign token_clear  = (state_r == ST_CLEAR);
  assign dl_detect_in = dl_detect_in_r;
  assign report_vld   = report_vld_r;
  assign report_id    = report_id_r;
  assign report_mask  = report_mask_r;
  assign report_len   = report_len_r;
  assign abort_pulse  = abort_pulse_r;

endmodule
